rc_adder_4: RTL and testbench

- Ripple-carry adder: WIDTH-bit operands a and b plus carry-in; default WIDTH is 4.
- The sum is built from a chain of 1-bit full-adder cells.
- Result and carry-out are registered, giving one clock of latency.
- Used as the basic arithmetic leaf in datapaths that need a small, predictable adder with a registered output.

---
 rtl/rc_adder_pkg.sv | 5 +
 rtl/full_adder_cell.sv | 13 +
 rtl/rc_adder_4.sv | 54 +++++
 tb/tb_rc_adder_4.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rc_adder_pkg.sv
// rc_adder_pkg: shared width default and widened result type for the ripple-carry adder
package rc_adder_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef logic [DEFAULT_WIDTH:0] result_t;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one combinational 1-bit full adder, the link of the ripple chain
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/rc_adder_4.sv
// rc_adder_4: registered ripple-carry adder built from explicit full_adder_cell instances
// Optional signed-overflow output ovf enabled by defining RC_ADDER_4_OVERFLOW_EN.
module rc_adder_4
    import rc_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef RC_ADDER_4_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s;
                cout <= c[WIDTH];
            end
        end
    end
`ifdef RC_ADDER_4_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else if (in_valid) ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_rc_adder_4.sv
// tb_rc_adder_4: random, directed and exhaustive checks of rc_adder_4 against an arithmetic model
module tb_rc_adder_4;
    import rc_adder_pkg::*;
    localparam int W = DEFAULT_WIDTH;
    logic         clk = 1'b0;
    logic         rst, in_valid, cin, cout, out_valid;
    logic [W-1:0] a, b, sum;
`ifdef RC_ADDER_4_OVERFLOW_EN
    logic         ovf;
`endif
    int      checks = 0, errors = 0;
    bit      go = 1'b0;
    result_t exp_r;
    logic    exp_v, exp_o;

    rc_adder_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef RC_ADDER_4_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic signed_ovf(logic [W-1:0] x, logic [W-1:0] y, logic ci);
        int sx, sy, t;
        sx = $signed(x);
        sy = $signed(y);
        t  = sx + sy + int'(ci);
        return (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result = a+b+cin as plain integers, captured on each valid edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_r <= '0;
            exp_v <= 1'b0;
            exp_o <= 1'b0;
        end else begin
            exp_v <= in_valid;
            if (in_valid) begin
                exp_r <= result_t'(a) + result_t'(b) + result_t'(cin);
                exp_o <= signed_ovf(a, b, cin);
            end
        end
    end

    always @(negedge clk) begin
        if (go && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            chk("sum", 32'(sum), 32'(exp_r[W-1:0]));
            chk("cout", 32'(cout), 32'(exp_r[W]));
`ifdef RC_ADDER_4_OVERFLOW_EN
            chk("ovf", 32'(ovf), 32'(exp_o));
`endif
        end
    end

    task automatic drive(logic v, logic [W-1:0] x, logic [W-1:0] y, logic ci);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
    endtask

    task automatic lit(string name, logic [W-1:0] s_exp, logic c_exp, logic v_exp);
        chk({name, "_sum"}, 32'(sum), 32'(s_exp));
        chk({name, "_cout"}, 32'(cout), 32'(c_exp));
        chk({name, "_valid"}, 32'(out_valid), 32'(v_exp));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'b0101, 4'b1001, 1'b1);
        #1;
        lit("reset", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        lit("reset_dominates", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        go  = 1'b1;
        drive(1'b1, 4'b1001, 4'b1011, 1'b0);
        @(negedge clk);
        lit("first", 4'b0100, 1'b1, 1'b1);
        drive(1'b1, 4'b1111, 4'b1000, 1'b1);
        @(negedge clk);
        lit("b2b", 4'b1000, 1'b1, 1'b1);
        drive(1'b0, 4'b0011, 4'b0011, 1'b0);
        @(negedge clk);
        lit("hold", 4'b1000, 1'b1, 1'b0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        @(negedge clk);
        lit("all_ones", 4'b1111, 1'b1, 1'b1);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        lit("zeros", 4'b0000, 1'b0, 1'b1);
        drive(1'b1, 4'b0111, 4'b0001, 1'b0);
        @(negedge clk);
        lit("ovf_case", 4'b1000, 1'b0, 1'b1);
`ifdef RC_ADDER_4_OVERFLOW_EN
        chk("ovf_lit", 32'(ovf), 32'd1);
`endif
        for (int i = 0; i < 2 ** (2 * W + 1); i++) begin
            drive(1'b1, W'(i >> (W + 1)), W'(i >> 1), i[0]);
            @(negedge clk);
        end
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
            if (i % 97 == 50) begin
                #2 rst = 1'b1;
                #1 lit("mid_reset", 4'b0000, 1'b0, 1'b0);
                #1 rst = 1'b0;
                in_valid = 1'b1;
            end
            @(negedge clk);
        end
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
